// File: rtl/stream_tz_counter.sv
// Trailing zero/one count across a multi-word packet, least-significant word first.
// Latency: result valid the cycle after the din_last word is accepted.
// Backpressure: din_ready is low while a result is held; dout is held until dout_ready.
module stream_tz_counter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 4,
    localparam int CW = $clog2(DATA_WIDTH * MAX_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  din_last,
    input  logic                  mode,
    output logic                  din_ready,
    output logic [CW-1:0]         dout,
    output logic                  dout_ovf,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int             WCW       = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] WCNT_MAX  = WCW'(MAX_WORDS);
    localparam logic [CW-1:0]  WORD_BITS = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]  ACC_MAX   = CW'(DATA_WIDTH * MAX_WORDS);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SKIP  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         acc, acc_nxt;
    logic [WCW-1:0]        wcnt, wcnt_nxt;
    logic                  ovf, ovf_nxt;
    logic                  mode_q;
    logic                  mode_eff;
    logic                  accept;
    logic                  full;
    logic                  load_out;
    logic [DATA_WIDTH-1:0] tgt;
    logic                  hit;
    logic [CW-1:0]         hit_idx;

    assign din_ready  = (state != DONE);
    assign dout_valid = (state == DONE);
    assign accept     = din_valid && din_ready;
    assign full       = (wcnt == WCNT_MAX);

    // Only word 0 samples the mode pin; later words use the captured copy.
    assign mode_eff = (wcnt == '0) ? mode : mode_q;
    assign tgt      = mode_eff ? ~din : din;
    assign hit      = |tgt;

    // Lowest set bit of the target vector wins.
    always_comb begin
        hit_idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (tgt[i]) begin
                hit_idx = CW'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        wcnt_nxt  = wcnt;
        ovf_nxt   = ovf;
        load_out  = 1'b0;
        case (state)
            ACCUM, SKIP: begin
                if (accept) begin
                    if (full) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                    // Words past MAX_WORDS never contribute to the count.
                    if (state == ACCUM && !full) begin
                        if (hit) begin
                            acc_nxt   = acc + hit_idx;
                            state_nxt = SKIP;
                        end else begin
                            acc_nxt = acc + WORD_BITS;
                        end
                    end
                    if (din_last) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (dout_ready) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    wcnt_nxt  = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ACCUM;
                acc_nxt   = '0;
                wcnt_nxt  = '0;
                ovf_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ACCUM;
            acc      <= '0;
            wcnt     <= '0;
            ovf      <= 1'b0;
            mode_q   <= 1'b0;
            dout     <= '0;
            dout_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            wcnt  <= wcnt_nxt;
            ovf   <= ovf_nxt;
            if (accept && wcnt == '0) begin
                mode_q <= mode;
            end
            if (load_out) begin
                dout     <= acc_nxt;
                dout_ovf <= ovf_nxt;
            end
        end
    end

    acc_bounded: assert property (@(posedge clk) disable iff (reset) acc <= ACC_MAX);

endmodule
